// File: rtl/program_run_controller.sv
// Loads instruction memory from a valid/ready stream, then gates CPU reset/enable for run, halt and single-step.
// Define PUC_BREAKPOINT_EN to compile in the pc == breakAddr breakpoint; otherwise RUN stops only on haltReq.
module program_run_controller #(
    parameter int PC_WIDTH          = 8,
    parameter int INSTRUCTION_WIDTH = 12
) (
    input  logic                         clock,
    input  logic                         isReset,
    input  logic                         loadStart,
    input  logic [PC_WIDTH-1:0]          loadCount,
    input  logic                         loadValid,
    input  logic [INSTRUCTION_WIDTH-1:0] loadData,
    output logic                         loadReady,
    output logic                         imemWe,
    output logic [PC_WIDTH-1:0]          imemAddr,
    output logic [INSTRUCTION_WIDTH-1:0] imemWData,
    input  logic                         runReq,
    input  logic                         stepReq,
    input  logic                         haltReq,
    input  logic [PC_WIDTH-1:0]          pc,
    input  logic [PC_WIDTH-1:0]          breakAddr,
    output logic                         cpuReset,
    output logic                         cpuEnable,
    output logic                         loadDone,
    output logic [2:0]                   state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RELEASE = 3'd2,
        HALTED  = 3'd3,
        RUN     = 3'd4,
        STEP    = 3'd5
    } state_t;

    state_t              cur_state;
    state_t              next_state;
    logic [PC_WIDTH-1:0] word_count;
    logic [PC_WIDTH-1:0] load_last;
    logic                accept;
    logic                last_word;
    logic                start_ok;
    logic                bp_hit;

    assign loadReady = (cur_state == LOAD);
    assign accept    = loadValid && (cur_state == LOAD);
    assign last_word = (word_count == load_last);
    assign start_ok  = loadStart && ((cur_state == IDLE) || (cur_state == HALTED));
    assign state     = cur_state;

`ifdef PUC_BREAKPOINT_EN
    logic bp_armed;

    assign bp_hit = bp_armed && (pc == breakAddr);

    // Disarm on resume so the instruction at the breakpoint runs once; re-arm once pc moves off it.
    always_ff @(posedge clock) begin
        if (isReset) begin
            bp_armed <= 1'b1;
        end else if ((cur_state == HALTED) && (next_state == RUN)) begin
            bp_armed <= 1'b0;
        end else if ((cur_state == RUN) && (pc != breakAddr)) begin
            bp_armed <= 1'b1;
        end
    end
`else
    logic unused_bp;

    assign unused_bp = ^{pc, breakAddr};
    assign bp_hit    = 1'b0;
`endif

    always_comb begin
        next_state = cur_state;
        cpuEnable  = 1'b0;
        case (cur_state)
            IDLE: begin
                if (loadStart) begin
                    next_state = LOAD;
                end else if (runReq) begin
                    next_state = RELEASE;
                end
            end
            LOAD: begin
                if (haltReq) begin
                    next_state = IDLE;
                end else if (accept && last_word) begin
                    next_state = RELEASE;
                end
            end
            RELEASE: begin
                cpuEnable  = 1'b1;
                next_state = HALTED;
            end
            HALTED: begin
                if (loadStart) begin
                    next_state = LOAD;
                end else if (stepReq) begin
                    next_state = STEP;
                end else if (runReq) begin
                    next_state = RUN;
                end
            end
            STEP: begin
                cpuEnable  = 1'b1;
                next_state = HALTED;
            end
            RUN: begin
                cpuEnable = !bp_hit;
                if (haltReq || bp_hit) begin
                    next_state = HALTED;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // cpuReset and loadDone are computed from next_state so they line up with the state they describe.
    always_ff @(posedge clock) begin
        if (isReset) begin
            cur_state  <= IDLE;
            cpuReset   <= 1'b1;
            imemWe     <= 1'b0;
            imemAddr   <= '0;
            imemWData  <= '0;
            loadDone   <= 1'b0;
            word_count <= '0;
            load_last  <= '0;
        end else begin
            cur_state <= next_state;
            cpuReset  <= !((next_state == HALTED) || (next_state == RUN) || (next_state == STEP));
            loadDone  <= (cur_state == LOAD) && (next_state == RELEASE);
            imemWe    <= accept;
            if (accept) begin
                imemAddr   <= word_count;
                imemWData  <= loadData;
                word_count <= word_count + 1'b1;
            end
            if (start_ok) begin
                load_last  <= loadCount;
                word_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_program_run_controller.sv
// Directed bench for program_run_controller with a tiny CPU pc model driven by cpuReset/cpuEnable.
`timescale 1ns/1ps
module tb_program_run_controller;

    logic        clock     = 1'b0;
    logic        isReset   = 1'b1;
    logic        loadStart = 1'b0;
    logic [7:0]  loadCount = 8'd0;
    logic        loadValid = 1'b0;
    logic [11:0] loadData  = 12'd0;
    logic        loadReady;
    logic        imemWe;
    logic [7:0]  imemAddr;
    logic [11:0] imemWData;
    logic        runReq    = 1'b0;
    logic        stepReq   = 1'b0;
    logic        haltReq   = 1'b0;
    logic [7:0]  pc        = 8'd0;
    logic [7:0]  breakAddr = 8'd0;
    logic        cpuReset;
    logic        cpuEnable;
    logic        loadDone;
    logic [2:0]  state;

    int vectors     = 0;
    int miscompares = 0;
    int en_cycles   = 0;

    program_run_controller #(.PC_WIDTH(8), .INSTRUCTION_WIDTH(12)) dut (
        .clock     (clock),
        .isReset   (isReset),
        .loadStart (loadStart),
        .loadCount (loadCount),
        .loadValid (loadValid),
        .loadData  (loadData),
        .loadReady (loadReady),
        .imemWe    (imemWe),
        .imemAddr  (imemAddr),
        .imemWData (imemWData),
        .runReq    (runReq),
        .stepReq   (stepReq),
        .haltReq   (haltReq),
        .pc        (pc),
        .breakAddr (breakAddr),
        .cpuReset  (cpuReset),
        .cpuEnable (cpuEnable),
        .loadDone  (loadDone),
        .state     (state)
    );

    always #5 clock = ~clock;

    // CPU stand-in: synchronous reset when enabled with cpuReset, else one instruction per enabled edge.
    always @(posedge clock) begin
        if (isReset) begin
            pc <= 8'd0;
        end else if (cpuEnable) begin
            pc <= cpuReset ? 8'd0 : pc + 8'd1;
        end
        if (!isReset && cpuEnable && !cpuReset) en_cycles <= en_cycles + 1;
    end

    task automatic test_reset();
        isReset = 1'b1;
        repeat (2) @(negedge clock);
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state); end
        vectors++; if (cpuReset !== 1'b1) begin miscompares++; $display("FAIL reset_cpuReset: got %b expected 1", cpuReset); end
        vectors++; if (cpuEnable !== 1'b0) begin miscompares++; $display("FAIL reset_cpuEnable: got %b expected 0", cpuEnable); end
        vectors++; if (imemWe !== 1'b0 || loadReady !== 1'b0 || loadDone !== 1'b0) begin
            miscompares++; $display("FAIL reset_outputs: got we=%b rdy=%b done=%b expected 0 0 0", imemWe, loadReady, loadDone);
        end
        isReset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [11:0] d [4];
        d[0] = 12'h101; d[1] = 12'h202; d[2] = 12'h303; d[3] = 12'h404;
        loadStart = 1'b1; loadCount = 8'd3;
        @(negedge clock);
        loadStart = 1'b0;
        vectors++; if (state !== 3'd1 || loadReady !== 1'b1 || cpuReset !== 1'b1) begin
            miscompares++; $display("FAIL b2b_enter_load: got state=%0d rdy=%b rst=%b expected 1 1 1", state, loadReady, cpuReset);
        end
        for (int i = 0; i < 4; i++) begin
            loadValid = 1'b1; loadData = d[i];
            @(negedge clock);
            vectors++; if (imemWe !== 1'b1 || imemAddr !== i[7:0] || imemWData !== d[i]) begin
                miscompares++; $display("FAIL b2b_write%0d: got we=%b addr=%h data=%h expected 1 %h %h", i, imemWe, imemAddr, imemWData, i[7:0], d[i]);
            end
            vectors++; if (loadDone !== 1'(i == 3)) begin
                miscompares++; $display("FAIL b2b_loadDone%0d: got %b expected %b", i, loadDone, 1'(i == 3));
            end
        end
        loadValid = 1'b0;
        vectors++; if (state !== 3'd2 || loadReady !== 1'b0 || cpuEnable !== 1'b1 || cpuReset !== 1'b1) begin
            miscompares++; $display("FAIL b2b_release: got state=%0d rdy=%b en=%b rst=%b expected 2 0 1 1", state, loadReady, cpuEnable, cpuReset);
        end
        @(negedge clock);
        vectors++; if (state !== 3'd3 || cpuReset !== 1'b0 || cpuEnable !== 1'b0 || imemWe !== 1'b0 || loadDone !== 1'b0) begin
            miscompares++; $display("FAIL b2b_halted: got state=%0d rst=%b en=%b we=%b done=%b expected 3 0 0 0 0", state, cpuReset, cpuEnable, imemWe, loadDone);
        end
        vectors++; if (pc !== 8'd0) begin miscompares++; $display("FAIL b2b_pc: got %0d expected 0", pc); end
    endtask

    task automatic test_load_gaps();
        logic [11:0] d [4];
        int g [3];
        d[0] = 12'hA01; d[1] = 12'hB02; d[2] = 12'hC03; d[3] = 12'hD04;
        g[0] = 0; g[1] = 2; g[2] = 5;
        loadStart = 1'b1; loadCount = 8'd3;
        @(negedge clock);
        loadStart = 1'b0;
        vectors++; if (state !== 3'd1 || cpuReset !== 1'b1) begin
            miscompares++; $display("FAIL gaps_enter_load: got state=%0d rst=%b expected 1 1", state, cpuReset);
        end
        for (int i = 0; i < 4; i++) begin
            loadValid = 1'b1; loadData = d[i];
            @(negedge clock);
            vectors++; if (imemWe !== 1'b1 || imemAddr !== i[7:0] || imemWData !== d[i]) begin
                miscompares++; $display("FAIL gaps_write%0d: got we=%b addr=%h data=%h expected 1 %h %h", i, imemWe, imemAddr, imemWData, i[7:0], d[i]);
            end
            loadValid = 1'b0;
            if (i < 3) begin
                for (int k = 0; k < g[i]; k++) begin
                    @(negedge clock);
                    vectors++; if (imemWe !== 1'b0 || state !== 3'd1) begin
                        miscompares++; $display("FAIL gaps_idle%0d_%0d: got we=%b state=%0d expected 0 1", i, k, imemWe, state);
                    end
                end
            end
        end
        vectors++; if (state !== 3'd2 || loadDone !== 1'b1) begin
            miscompares++; $display("FAIL gaps_release: got state=%0d done=%b expected 2 1", state, loadDone);
        end
        @(negedge clock);
        vectors++; if (state !== 3'd3 || loadDone !== 1'b0) begin
            miscompares++; $display("FAIL gaps_halted: got state=%0d done=%b expected 3 0", state, loadDone);
        end
    endtask

    task automatic test_step();
        int base;
        base = en_cycles;
        for (int i = 0; i < 3; i++) begin
            stepReq = 1'b1;
            @(negedge clock);
            stepReq = 1'b0;
            vectors++; if (state !== 3'd5 || cpuEnable !== 1'b1) begin
                miscompares++; $display("FAIL step%0d_active: got state=%0d en=%b expected 5 1", i, state, cpuEnable);
            end
            @(negedge clock);
            vectors++; if (state !== 3'd3 || cpuEnable !== 1'b0) begin
                miscompares++; $display("FAIL step%0d_halted: got state=%0d en=%b expected 3 0", i, state, cpuEnable);
            end
        end
        vectors++; if (pc !== 8'd3) begin miscompares++; $display("FAIL step_pc: got %0d expected 3", pc); end
        vectors++; if (en_cycles - base !== 3) begin miscompares++; $display("FAIL step_count: got %0d expected 3", en_cycles - base); end
    endtask

    task automatic test_run();
        int n;
        int stalls;
        logic [7:0] stop_pc;
        breakAddr = 8'd5;
        runReq = 1'b1;
        @(negedge clock);
        runReq = 1'b0;
        vectors++; if (state !== 3'd4 || cpuEnable !== 1'b1 || pc !== 8'd3) begin
            miscompares++; $display("FAIL run_start: got state=%0d en=%b pc=%0d expected 4 1 3", state, cpuEnable, pc);
        end
`ifdef PUC_BREAKPOINT_EN
        n = 0;
        while (pc !== 8'd5 && n < 20) begin @(negedge clock); n++; end
        vectors++; if (pc !== 8'd5) begin miscompares++; $display("FAIL run_bp_timeout: got pc=%0d expected 5", pc); end
        vectors++; if (cpuEnable !== 1'b0) begin miscompares++; $display("FAIL run_bp_gate: got en=%b expected 0", cpuEnable); end
        @(negedge clock);
        vectors++; if (state !== 3'd3 || pc !== 8'd5) begin
            miscompares++; $display("FAIL run_bp_halted: got state=%0d pc=%0d expected 3 5", state, pc);
        end
        runReq = 1'b1;
        @(negedge clock);
        runReq = 1'b0;
        vectors++; if (state !== 3'd4 || cpuEnable !== 1'b1 || pc !== 8'd5) begin
            miscompares++; $display("FAIL run_resume: got state=%0d en=%b pc=%0d expected 4 1 5", state, cpuEnable, pc);
        end
        @(negedge clock);
        vectors++; if (pc !== 8'd6 || cpuEnable !== 1'b1) begin
            miscompares++; $display("FAIL run_past_bp: got pc=%0d en=%b expected 6 1", pc, cpuEnable);
        end
        stop_pc = 8'd7;
`else
        n = 0; stalls = 0;
        while (pc !== 8'd8 && n < 20) begin
            @(negedge clock); n++;
            if (cpuEnable !== 1'b1) stalls++;
        end
        vectors++; if (pc !== 8'd8) begin miscompares++; $display("FAIL run_timeout: got pc=%0d expected 8", pc); end
        vectors++; if (stalls !== 0) begin miscompares++; $display("FAIL run_no_bp: got %0d stalled cycles expected 0", stalls); end
        stop_pc = 8'd9;
`endif
        haltReq = 1'b1;
        @(negedge clock);
        haltReq = 1'b0;
        vectors++; if (state !== 3'd3 || cpuEnable !== 1'b0 || pc !== stop_pc) begin
            miscompares++; $display("FAIL run_halt: got state=%0d en=%b pc=%0d expected 3 0 %0d", state, cpuEnable, pc, stop_pc);
        end
        @(negedge clock);
        vectors++; if (pc !== stop_pc) begin miscompares++; $display("FAIL run_halt_hold: got pc=%0d expected %0d", pc, stop_pc); end
    endtask

    task automatic test_reset_midload();
        loadStart = 1'b1; loadCount = 8'd5;
        @(negedge clock);
        loadStart = 1'b0;
        for (int i = 0; i < 2; i++) begin
            loadValid = 1'b1; loadData = 12'h7A0 + 12'(i);
            @(negedge clock);
            vectors++; if (imemWe !== 1'b1 || imemAddr !== i[7:0]) begin
                miscompares++; $display("FAIL midload_write%0d: got we=%b addr=%h expected 1 %h", i, imemWe, imemAddr, i[7:0]);
            end
        end
        loadData = 12'h7A2;
        isReset = 1'b1;
        @(negedge clock);
        isReset = 1'b0;
        vectors++; if (state !== 3'd0 || imemWe !== 1'b0 || loadReady !== 1'b0 || cpuReset !== 1'b1 || cpuEnable !== 1'b0) begin
            miscompares++; $display("FAIL midload_reset: got state=%0d we=%b rdy=%b rst=%b en=%b expected 0 0 0 1 0", state, imemWe, loadReady, cpuReset, cpuEnable);
        end
        vectors++; if (imemAddr !== 8'd0) begin miscompares++; $display("FAIL midload_addr: got %h expected 00", imemAddr); end
        @(negedge clock);
        loadValid = 1'b0;
        vectors++; if (imemWe !== 1'b0 || state !== 3'd0) begin
            miscompares++; $display("FAIL midload_after: got we=%b state=%0d expected 0 0", imemWe, state);
        end
        runReq = 1'b1;
        @(negedge clock);
        runReq = 1'b0;
        vectors++; if (state !== 3'd2 || loadDone !== 1'b0 || cpuEnable !== 1'b1) begin
            miscompares++; $display("FAIL idle_run_release: got state=%0d done=%b en=%b expected 2 0 1", state, loadDone, cpuEnable);
        end
        @(negedge clock);
        vectors++; if (state !== 3'd3) begin miscompares++; $display("FAIL idle_run_halted: got state=%0d expected 3", state); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_gaps();
        test_step();
        test_run();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
